// File: rtl/rf_pkg.sv
// Shared widths and index type for the register file and its scoreboard.
// Latency: none (types and constants only).
// Backpressure: none (no handshakes live here).
package rf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // Register index at the default register-file depth.
    typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle into the register file: read, write and issue ports.
// Latency: reads are combinational; write and issue land on the next clk edge.
// Backpressure: none; the scoreboard busy flags tell decode when to stall.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W:0]   busy_cnt;

    // Pipeline side: decode drives read/issue, writeback drives the write port.
    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt
    );

    // Register file side.
    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data_a, rd_data_b, busy_a, busy_b, busy_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-result vector: clear on writeback, set on issue, set wins.
// Latency: busy vector and busy_cnt update one clk edge after clr/set.
// Backpressure: none; callers pre-qualify clr_en/set_en (e.g. hardwired r0).
module rf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]      busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_nxt;

    // Next busy vector: clear applied first so a same-cycle issue re-marks the register.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
    end

    // Popcount of the next vector so busy_cnt always matches the registered busy bits.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    // Busy bits and their count; reset discards every outstanding reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// CPU register file: clocked write, two bypassed combinational reads, busy scoreboard.
// Latency: reads 0 cycles (same-cycle write forwarded); write/issue visible after 1 edge.
// Backpressure: none; busy_a/busy_b let decode stall on pending producers.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;
    logic              iss_ok;
    logic              zero_a, zero_b;
    logic              byp_a, byp_b;

    // A hardwired r0 swallows both writes and reservations.
    assign wr_ok  = bus.wr_en    && !(ZERO_REG && (bus.wr_addr    == '0));
    assign iss_ok = bus.issue_en && !(ZERO_REG && (bus.issue_addr == '0));

    // Forwarding is held off in reset so outputs read as zero while rst_n is low.
    assign zero_a = ZERO_REG && (bus.rd_addr_a == '0);
    assign zero_b = ZERO_REG && (bus.rd_addr_b == '0);
    assign byp_a  = rst_n && wr_ok && (bus.wr_addr == bus.rd_addr_a);
    assign byp_b  = rst_n && wr_ok && (bus.wr_addr == bus.rd_addr_b);

    // Data array: cleared asynchronously, written on the edge by writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read muxes: r0 zero first, then writeback forwarding, then the array.
    always_comb begin
        bus.rd_data_a = mem[bus.rd_addr_a];
        bus.busy_a    = busy[bus.rd_addr_a];
        if (zero_a) begin
            bus.rd_data_a = '0;
            bus.busy_a    = 1'b0;
        end else if (byp_a) begin
            bus.rd_data_a = bus.wr_data;
            bus.busy_a    = 1'b0;
        end
        bus.rd_data_b = mem[bus.rd_addr_b];
        bus.busy_b    = busy[bus.rd_addr_b];
        if (zero_b) begin
            bus.rd_data_b = '0;
            bus.busy_b    = 1'b0;
        end else if (byp_b) begin
            bus.rd_data_b = bus.wr_data;
            bus.busy_b    = 1'b0;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (wr_ok),
        .clr_addr (bus.wr_addr),
        .set_en   (iss_ok),
        .set_addr (bus.issue_addr),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: vector table plus reset/fill/small-build sequences.
// Latency: drives inputs 1 time unit after posedge, samples 1 unit later.
// Backpressure: not applicable.
module tb_regfile_scoreboard;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(3)) sbus ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(3)) zbus ();

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b1)) dut_s (
        .clk (clk), .rst_n (rst_n), .bus (sbus)
    );
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0)) dut_z (
        .clk (clk), .rst_n (rst_n), .bus (zbus)
    );

    // The ordinary-r0 small build mirrors the stimulus of the hardwired-r0 small build.
    assign zbus.rd_addr_a  = sbus.rd_addr_a;
    assign zbus.rd_addr_b  = sbus.rd_addr_b;
    assign zbus.wr_en      = sbus.wr_en;
    assign zbus.wr_addr    = sbus.wr_addr;
    assign zbus.wr_data    = sbus.wr_data;
    assign zbus.issue_en   = sbus.issue_en;
    assign zbus.issue_addr = sbus.issue_addr;

    typedef struct {
        logic        wr_en;
        reg_idx_t    wr_addr;
        logic [31:0] wr_data;
        logic        issue_en;
        reg_idx_t    issue_addr;
        reg_idx_t    ra;
        reg_idx_t    rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eba;
        logic        ebb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_big();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.issue_en = 1'b0; bus.issue_addr = '0;
    endtask

    initial begin
        idle_big();
        bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd6;
        sbus.wr_en = 1'b0; sbus.wr_addr = '0; sbus.wr_data = '0;
        sbus.issue_en = 1'b0; sbus.issue_addr = '0;
        sbus.rd_addr_a = '0; sbus.rd_addr_b = '0;

        //        wr  waddr  wdata          iss addr   ra     rb     exp_a          exp_b          ba    bb    cnt
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5,  5'd6,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        tbl[3]  = '{1'b1, 5'd7, 32'h1234,     1'b0, 5'd0, 5'd7,  5'd5,  32'h1234,     32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        tbl[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  5'd7,  32'h0,        32'h1234,     1'b0, 1'b0, 6'd0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3,  5'd3,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd7,  32'h0,        32'h1234,     1'b1, 1'b0, 6'd1};
        tbl[8]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 5'd3,  5'd3,  32'h55,       32'h55,       1'b0, 1'b0, 6'd1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd5,  32'h55,       32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        tbl[10] = '{1'b1, 5'd3, 32'h5A,       1'b1, 5'd3, 5'd3,  5'd4,  32'h5A,       32'h0,        1'b0, 1'b0, 6'd0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3,  5'd4,  32'h5A,       32'h0,        1'b1, 1'b0, 6'd1};
        tbl[12] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd9, 5'd4,  5'd9,  32'h44,       32'h0,        1'b0, 1'b0, 6'd1};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd4,  32'h0,        32'h44,       1'b1, 1'b0, 6'd2};
        tbl[14] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 5'd9,  5'd3,  32'h0,        32'h33,       1'b1, 1'b0, 6'd2};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd3,  32'h0,        32'h33,       1'b1, 1'b0, 6'd1};
        tbl[16] = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd9,  5'd9,  32'h99,       32'h99,       1'b0, 1'b0, 6'd1};
        tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  5'd31, 32'h99,       32'h0,        1'b0, 1'b0, 6'd0};

        // Reset state, held across an edge.
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rd_a", 64'(bus.rd_data_a), 64'h0);
        chk("reset_busy_a", 64'(bus.busy_a), 64'h0);
        chk("reset_cnt", 64'(bus.busy_cnt), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors: one cycle each, checked before the edge.
        for (int v = 0; v < 18; v++) begin
            bus.wr_en = tbl[v].wr_en; bus.wr_addr = tbl[v].wr_addr; bus.wr_data = tbl[v].wr_data;
            bus.issue_en = tbl[v].issue_en; bus.issue_addr = tbl[v].issue_addr;
            bus.rd_addr_a = tbl[v].ra; bus.rd_addr_b = tbl[v].rb;
            #1;
            chk($sformatf("v%0d_rd_a", v), 64'(bus.rd_data_a), 64'(tbl[v].ea));
            chk($sformatf("v%0d_rd_b", v), 64'(bus.rd_data_b), 64'(tbl[v].eb));
            chk($sformatf("v%0d_busy_a", v), 64'(bus.busy_a), 64'(tbl[v].eba));
            chk($sformatf("v%0d_busy_b", v), 64'(bus.busy_b), 64'(tbl[v].ebb));
            chk($sformatf("v%0d_cnt", v), 64'(bus.busy_cnt), 64'(tbl[v].ecnt));
            @(posedge clk); #1;
        end
        idle_big();

        // Fill: reserve every nonzero register, then write each back with its index.
        for (int r = 1; r < 32; r++) begin
            bus.issue_en = 1'b1; bus.issue_addr = 5'(r);
            @(posedge clk); #1;
        end
        idle_big();
        bus.rd_addr_a = 5'd31; bus.rd_addr_b = 5'd1;
        #1;
        chk("fill_cnt", 64'(bus.busy_cnt), 64'd31);
        chk("fill_busy_a", 64'(bus.busy_a), 64'h1);
        chk("fill_busy_b", 64'(bus.busy_b), 64'h1);
        @(posedge clk); #1;
        for (int r = 1; r < 32; r++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'(r); bus.wr_data = 32'(r) * 32'h0101;
            @(posedge clk); #1;
        end
        idle_big();
        bus.rd_addr_a = 5'd17; bus.rd_addr_b = 5'd31;
        #1;
        chk("drain_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("drain_rd_a", 64'(bus.rd_data_a), 64'h1111);
        chk("drain_rd_b", 64'(bus.rd_data_b), 64'h1F1F);
        chk("drain_busy_b", 64'(bus.busy_b), 64'h0);

        // Mid-run reset: a pending reservation and stored data vanish without an edge.
        @(posedge clk); #1;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd20;
        @(posedge clk); #1;
        idle_big();
        bus.rd_addr_a = 5'd17; bus.rd_addr_b = 5'd20;
        #1;
        chk("pre_rst_busy_b", 64'(bus.busy_b), 64'h1);
        chk("pre_rst_cnt", 64'(bus.busy_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_a", 64'(bus.rd_data_a), 64'h0);
        chk("midrst_busy_b", 64'(bus.busy_b), 64'h0);
        chk("midrst_cnt", 64'(bus.busy_cnt), 64'd0);
        #1;
        rst_n = 1'b1;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd5;
        @(posedge clk); #1;
        idle_big();
        bus.rd_addr_a = 5'd5;
        #1;
        chk("post_rst_busy_a", 64'(bus.busy_a), 64'h1);
        chk("post_rst_cnt", 64'(bus.busy_cnt), 64'd1);

        // Small builds: reserve all eight indices; hardwired r0 tops out at 7, ordinary at 8.
        for (int r = 0; r < 8; r++) begin
            sbus.issue_en = 1'b1; sbus.issue_addr = 3'(r);
            @(posedge clk); #1;
        end
        sbus.issue_en = 1'b0;
        sbus.rd_addr_a = 3'd0; sbus.rd_addr_b = 3'd7;
        #1;
        chk("small_z1_cnt", 64'(sbus.busy_cnt), 64'd7);
        chk("small_z0_cnt", 64'(zbus.busy_cnt), 64'd8);
        chk("small_z1_busy_r0", 64'(sbus.busy_a), 64'h0);
        chk("small_z0_busy_r0", 64'(zbus.busy_a), 64'h1);
        sbus.wr_en = 1'b1; sbus.wr_addr = 3'd0; sbus.wr_data = 32'hA5;
        #1;
        chk("small_z1_byp_r0", 64'(sbus.rd_data_a), 64'h0);
        chk("small_z0_byp_r0", 64'(zbus.rd_data_a), 64'hA5);
        @(posedge clk); #1;
        sbus.wr_en = 1'b0;
        #1;
        chk("small_z1_rd_r0", 64'(sbus.rd_data_a), 64'h0);
        chk("small_z0_rd_r0", 64'(zbus.rd_data_a), 64'hA5);
        chk("small_z1_cnt2", 64'(sbus.busy_cnt), 64'd7);
        chk("small_z0_cnt2", 64'(zbus.busy_cnt), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
